// File: rtl/vmul_share_ctrl.sv
// rtl/vmul_share_ctrl.sv - two-requester 16x16 multiplier built on one shared external 8x8 multiplier
module vmul_share_ctrl #(
    parameter int HALF = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic                req1_valid,
    output logic                req0_ready,
    output logic                req1_ready,
    input  logic [2*HALF-1:0]   req0_a,
    input  logic [2*HALF-1:0]   req0_b,
    input  logic [2*HALF-1:0]   req1_a,
    input  logic [2*HALF-1:0]   req1_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [4*HALF-1:0]   rsp_p,
    output logic [HALF-1:0]     mul_a,
    output logic [HALF-1:0]     mul_b,
    input  logic [2*HALF:0]     mul_p,
    output logic                busy
);

    localparam int W  = 2 * HALF;
    localparam int PW = 4 * HALF;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t          state_q;
    logic [1:0]      step_q;
    logic [PW-1:0]   acc_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            id_q;
    logic            last_q;

    logic            idle;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic [PW-1:0]   p_ext;
    logic [PW-1:0]   term;
    logic [PW-1:0]   acc_d;

    // On a tie the requester that did not win last time is granted.
    assign idle       = (state_q == IDLE);
    assign grant0     = req0_valid & (~req1_valid | last_q);
    assign grant1     = req1_valid & (~req0_valid | ~last_q);
    assign req0_ready = idle & grant0;
    assign req1_ready = idle & grant1;
    assign accept     = req0_ready | req1_ready;

    // Carry bit of the 8x8 result is masked off; the partial product never needs it.
    assign p_ext = PW'(mul_p & {1'b0, {W{1'b1}}});

    always_comb begin
        term = p_ext;
        case (step_q)
            2'd1, 2'd2: term = p_ext << HALF;
            2'd3:       term = p_ext << (2 * HALF);
            default:    term = p_ext;
        endcase
    end

    assign acc_d = acc_q + term;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state_q == MUL) begin
            mul_a = step_q[0] ? a_q[W-1:HALF] : a_q[HALF-1:0];
            mul_b = step_q[1] ? b_q[W-1:HALF] : b_q[HALF-1:0];
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rsp_p     = acc_q;
    assign rsp_id    = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= req1_ready ? req1_a : req0_a;
                        b_q     <= req1_ready ? req1_b : req0_b;
                        id_q    <= req1_ready;
                        last_q  <= req1_ready;
                        acc_q   <= '0;
                        step_q  <= 2'd0;
                        state_q <= MUL;
                    end
                end
                MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmul_share_ctrl.sv
// tb/tb_vmul_share_ctrl.sv - scoreboard bench for vmul_share_ctrl
module tb_vmul_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req1_valid = 1'b0;
    logic        req0_ready;
    logic        req1_ready;
    logic [15:0] req0_a = '0;
    logic [15:0] req0_b = '0;
    logic [15:0] req1_a = '0;
    logic [15:0] req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_p;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [16:0] mul_p;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_edge = 0;
    logic rv_prev = 1'b0;
    logic [32:0] sb[$];
    logic [32:0] sb_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the shared 8x8 multiplier.
    assign mul_p = {9'd0, mul_a} * {9'd0, mul_b};

    vmul_share_ctrl #(.HALF(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
    );

    // Scoreboard: push on accept, pop on response handshake, check latency.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req0_ready && req1_ready) begin
                n_cmp++; n_err++;
                $display("FAIL dual_ready: both readys high");
            end
            if (req0_ready) begin
                sb.push_back({1'b0, {16'd0, req0_a} * {16'd0, req0_b}});
                acc_edge = cyc + 1;
            end else if (req1_ready) begin
                sb.push_back({1'b1, {16'd0, req1_a} * {16'd0, req1_b}});
                acc_edge = cyc + 1;
            end
            if (rsp_valid && !rv_prev) begin
                n_cmp++;
                if (cyc !== acc_edge + 4) begin
                    n_err++;
                    $display("FAIL latency: got %0d edges, want 4", cyc - acc_edge);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL stale_rsp: id=%0d p=%h with nothing outstanding", rsp_id, rsp_p);
                end else begin
                    sb_exp = sb.pop_front();
                    if ({rsp_id, rsp_p} !== sb_exp) begin
                        n_err++;
                        $display("FAIL sb_rsp: got id=%0d p=%h, want id=%0d p=%h",
                                 rsp_id, rsp_p, sb_exp[32], sb_exp[31:0]);
                    end
                end
            end
        end
        rv_prev = rsp_valid;
    end

    task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        forever begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            n++;
            if (n > 30) begin
                n_cmp++; n_err++;
                $display("FAIL issue_timeout: id=%0d never accepted", id);
                break;
            end
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) break;
            n++;
            if (n > 30) begin
                n_cmp++; n_err++;
                $display("FAIL rsp_timeout: no handshake within 30 cycles");
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        n_cmp++;
        if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b, want 0000", {rsp_valid, busy, req0_ready, req1_ready});
        end
        n_cmp++;
        if ({mul_a, mul_b} !== 16'h0) begin
            n_err++; $display("FAIL reset_mul: got %h, want 0000", {mul_a, mul_b});
        end
        n_cmp++;
        if ({rsp_id, rsp_p} !== 33'h0) begin
            n_err++; $display("FAIL reset_rsp: got id=%0d p=%h, want 0/0", rsp_id, rsp_p);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int n;
        int e_prev = 0;
        rsp_ready = 1'b1;
        req0_a = 16'h1111; req0_b = 16'h2222;
        req1_a = 16'h3333; req1_b = 16'h4444;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (req0_ready || req1_ready) break;
                n++;
                if (n > 30) break;
            end
            n_cmp++;
            if (n > 30 || req1_ready !== g[0]) begin
                n_err++; $display("FAIL rr_grant%0d: got req1_ready=%b timeout=%0d, want %0d", g, req1_ready, n > 30, g[0]);
            end
            if (g > 0) begin
                n_cmp++;
                if (cyc + 1 - e_prev !== 6) begin
                    n_err++; $display("FAIL throughput%0d: got %0d cycles, want 6", g, cyc + 1 - e_prev);
                end
            end
            e_prev = cyc + 1;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp();
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        issue(1'b0, 16'h1234, 16'h5678);
        wait_rsp();
        n_cmp++;
        if (rsp_p !== 32'h06260060 || rsp_id !== 1'b0) begin
            n_err++; $display("FAIL single: got id=%0d p=%h, want 0/06260060", rsp_id, rsp_p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_step_trace();
        logic [15:0] exp_t[4] = '{16'hB2D4, 16'hA1D4, 16'hB2C3, 16'hA1C3};
        rsp_ready = 1'b1;
        issue(1'b0, 16'hA1B2, 16'hC3D4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({mul_a, mul_b} !== exp_t[k] || busy !== 1'b1) begin
                n_err++; $display("FAIL step%0d: got %h busy=%b, want %h busy=1", k, {mul_a, mul_b}, busy, exp_t[k]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({mul_a, mul_b} !== 16'h0 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL step_done: got mul=%h rsp_valid=%b, want 0000/1", {mul_a, mul_b}, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_corner();
        logic [15:0] ta[3] = '{16'hFFFF, 16'h0000, 16'h0100};
        logic [15:0] tb_[3] = '{16'hFFFF, 16'hABCD, 16'h0100};
        logic [31:0] tp[3] = '{32'hFFFE0001, 32'h00000000, 32'h00010000};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, ta[i], tb_[i]);
            wait_rsp();
            n_cmp++;
            if (rsp_p !== tp[i] || rsp_id !== 1'b1) begin
                n_err++; $display("FAIL corner%0d: got id=%0d p=%h, want 1/%h", i, rsp_id, rsp_p, tp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic [31:0] exp_p;
        exp_p = 32'hBEEF * 32'h1234;
        rsp_ready = 1'b0;
        issue(1'b1, 16'hBEEF, 16'h1234);
        while (!rsp_valid && n < 30) begin
            @(negedge clk); n++;
        end
        req0_a = 16'h0F0F; req0_b = 16'h1010; req1_a = 16'h2020; req1_b = 16'h3030;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_p !== exp_p || rsp_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold%0d: got v=%b p=%h id=%0d rdy=%b%b busy=%b, want 1/%h/1/00/1",
                         c, rsp_valid, rsp_p, rsp_id, req0_ready, req1_ready, busy, exp_p);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_release: got rsp_valid=%b, want 1", rsp_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL bp_after: got v=%b busy=%b, want 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        issue(1'b0, 16'h4321, 16'h8765);
        @(negedge clk);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rsp_valid, busy, mul_a, mul_b, rsp_id, rsp_p} !== 51'h0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b busy=%b mul=%h id=%0d p=%h, want all 0",
                     rsp_valid, busy, {mul_a, mul_b}, rsp_id, rsp_p);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++; $display("FAIL no_stale%0d: got v=%b busy=%b, want 0/0", c, rsp_valid, busy);
            end
        end
        @(posedge clk); #1;
        issue(1'b1, 16'h0003, 16'h0005);
        wait_rsp();
        n_cmp++;
        if (rsp_p !== 32'h0000000F || rsp_id !== 1'b1) begin
            n_err++; $display("FAIL post_reset: got id=%0d p=%h, want 1/0000000F", rsp_id, rsp_p);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_step_trace();
        test_corner();
        test_backpressure();
        test_reset_mid();
        @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL sb_leftover: got %0d outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
